// File: rtl/counter_arbiter_if.sv
// Requester-side handshake bundle for counter_arbiter: two request lines,
// one opcode per requester, one-hot grant and one-cycle done pulses.
interface counter_arbiter_if;
    logic [1:0] req;
    logic [2:0] op0;
    logic [2:0] op1;
    logic [1:0] gnt;
    logic [1:0] done;

    // requester side drives requests/opcodes and watches grant/done
    modport master (
        output req, op0, op1,
        input  gnt, done
    );

    // arbiter side
    modport slave (
        input  req, op0, op1,
        output gnt, done
    );
endinterface

// File: rtl/counter_arbiter.sv
// Shares one COUNT-bit up/down counter between two requesters.
// Round-robin arbitration, one operation per grant, IDLE->GRANT->EXEC->DONE.
// freeze stalls everything; saturation selects clamp vs modulo arithmetic.
module counter_arbiter #(
    parameter int COUNT       = 4,
    parameter int INCREMENT_1 = 1,
    parameter int INCREMENT_3 = 3,
    parameter int START       = 0,
    parameter int END         = 15
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    counter_arbiter_if.slave     bus,
    input  logic                 freeze,
    input  logic                 saturation,
    output logic                 busy,
    output logic [COUNT-1:0]     counter,
    output logic                 last_owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_INC1  = 3'd1;
    localparam logic [2:0] OP_INC3  = 3'd2;
    localparam logic [2:0] OP_DEC1  = 3'd3;
    localparam logic [2:0] OP_DEC3  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    // arithmetic runs one bit wider so carry/borrow is visible for clamping
    localparam logic [COUNT:0]   STEP_S  = (COUNT+1)'(INCREMENT_1);
    localparam logic [COUNT:0]   STEP_L  = (COUNT+1)'(INCREMENT_3);
    localparam logic [COUNT:0]   END_W   = (COUNT+1)'(END);
    localparam logic [COUNT-1:0] START_V = COUNT'(START);
    localparam logic [COUNT-1:0] END_V   = COUNT'(END);

    state_t           state, state_nxt;
    logic             winner;
    logic             arb_pick;
    logic [2:0]       op_q;
    logic [COUNT-1:0] counter_nxt;
    logic [COUNT:0]   wide_cnt;
    logic [1:0]       gnt_c;
    logic [1:0]       done_c;

    // upward result: clamp to END in saturating mode, else drop the carry
    function automatic logic [COUNT-1:0] fold_up(input logic [COUNT:0] v, input logic sat);
        if (sat && (v > END_W))
            return END_V;
        return v[COUNT-1:0];
    endfunction

    // downward result: a set MSB means the subtraction borrowed below zero
    function automatic logic [COUNT-1:0] fold_dn(input logic [COUNT:0] v, input logic sat);
        if (sat && (v[COUNT] || (v[COUNT-1:0] < START_V)))
            return START_V;
        return v[COUNT-1:0];
    endfunction

    // sole requester wins; on a tie the one that did not go last wins
    always_comb begin
        arb_pick = bus.req[1];
        if (bus.req == 2'b11)
            arb_pick = ~last_owner;
    end

    // state register
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state: freeze holds the current state
    always_comb begin
        state_nxt = state;
        if (!freeze) begin
            unique case (state)
                S_IDLE:  if (|bus.req) state_nxt = S_GRANT;
                S_GRANT: state_nxt = bus.req[winner] ? S_EXEC : S_IDLE;
                S_EXEC:  state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // outputs decoded from the registered state; done is masked while frozen
    always_comb begin
        gnt_c  = '0;
        done_c = '0;
        busy   = (state != S_IDLE);
        unique case (state)
            S_GRANT, S_EXEC: gnt_c[winner] = 1'b1;
            S_DONE:          if (!freeze) done_c[winner] = 1'b1;
            default: ;
        endcase
    end

    assign bus.gnt  = gnt_c;
    assign bus.done = done_c;

    // counter result for the latched opcode; saturation only matters in EXEC
    always_comb begin
        wide_cnt    = {1'b0, counter};
        counter_nxt = counter;
        unique case (op_q)
            OP_INC1:  counter_nxt = fold_up(wide_cnt + STEP_S, saturation);
            OP_INC3:  counter_nxt = fold_up(wide_cnt + STEP_L, saturation);
            OP_DEC1:  counter_nxt = fold_dn(wide_cnt - STEP_S, saturation);
            OP_DEC3:  counter_nxt = fold_dn(wide_cnt - STEP_L, saturation);
            OP_CLEAR: counter_nxt = START_V;
            default:  counter_nxt = counter;
        endcase
    end

    // datapath registers advance with the FSM, all held under freeze
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            winner     <= 1'b0;
            op_q       <= OP_NOP;
            counter    <= START_V;
            last_owner <= 1'b1;
        end else if (!freeze) begin
            unique case (state)
                S_IDLE:  if (|bus.req) winner <= arb_pick;
                S_GRANT: if (bus.req[winner]) op_q <= winner ? bus.op1 : bus.op0;
                S_EXEC:  counter <= counter_nxt;
                S_DONE:  last_owner <= winner;
                default: ;
            endcase
        end
    end

endmodule
